// File: rtl/dvp_tx.sv
// OV7670-style DVP source: serialises a 16-bit pixel stream onto p_clock/vsync/href/p_data.
// p_clock runs at clk/2; all frame timing and data change on the clk edge where p_clock falls.
module dvp_tx #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BP_LINES    = 17,
  parameter int V_FP_LINES    = 10,
  parameter logic [15:0] UNDERRUN_FILL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        p_clock,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_start,
  output logic        underrun
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int V_MAX_A  = (VSYNC_LINES > V_BP_LINES) ? VSYNC_LINES : V_BP_LINES;
  localparam int V_MAX_B  = (V_ACTIVE > V_FP_LINES) ? V_ACTIVE : V_FP_LINES;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int H_W      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int V_W      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(LINE_LEN - 1);
  localparam logic [H_W:0]   HREF_END = (H_W + 1)'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

  state_t          state_q, state_d;
  logic [H_W-1:0]  h_q, h_d;
  logic [V_W-1:0]  v_q, v_d;
  logic            p_clock_q;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      p_data_q, p_data_d;
  logic            frame_start_q, frame_start_d;
  logic            underrun_q, underrun_d;
  logic [7:0]      lo_q;
  logic            tick;
  logic            fetch;
  logic            enter_vsync;
  logic [15:0]     pix_word;

  function automatic logic [V_W-1:0] last_line(input state_t st);
    case (st)
      ST_VSYNC:  return V_W'(VSYNC_LINES - 1);
      ST_VBP:    return V_W'(V_BP_LINES - 1);
      ST_ACTIVE: return V_W'(V_ACTIVE - 1);
      ST_VFP:    return V_W'(V_FP_LINES - 1);
      default:   return '0;
    endcase
  endfunction

  // Successor of a vertical region; zero-length blanking regions are skipped.
  function automatic state_t next_region(input state_t st, input logic en);
    state_t nx;
    nx = ST_IDLE;
    case (st)
      ST_VSYNC: begin
        if (V_BP_LINES > 0) nx = ST_VBP;
        else                nx = ST_ACTIVE;
      end
      ST_VBP:   nx = ST_ACTIVE;
      ST_ACTIVE: begin
        if (V_FP_LINES > 0) nx = ST_VFP;
        else if (en)        nx = ST_VSYNC;
        else                nx = ST_IDLE;
      end
      default: begin
        if (en) nx = ST_VSYNC;
        else    nx = ST_IDLE;
      end
    endcase
    return nx;
  endfunction

  always_comb begin
    tick    = p_clock_q;
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (state_q == ST_IDLE) begin
      if (enable) state_d = ST_VSYNC;
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == last_line(state_q)) begin
        state_d = next_region(state_q, enable);
        v_d     = '0;
      end else begin
        v_d = v_q + 1'b1;
      end
    end else begin
      h_d = h_q + 1'b1;
    end

    enter_vsync = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
    vsync_d     = (state_d == ST_VSYNC);
    href_d      = (state_d == ST_ACTIVE) && ({1'b0, h_d} < HREF_END);
    fetch       = href_d && !h_d[0];
    pix_word    = pix_valid ? pix_data : UNDERRUN_FILL;

    p_data_d = '0;
    if (fetch)       p_data_d = pix_word[15:8];
    else if (href_d) p_data_d = lo_q;

    // A fill slot on the same tick as the vsync entry must win.
    underrun_d = underrun_q;
    if (enter_vsync)         underrun_d = 1'b0;
    if (fetch && !pix_valid) underrun_d = 1'b1;

    frame_start_d = tick && enter_vsync;
    pix_ready     = tick && fetch;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_clock_q     <= 1'b0;
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      p_data_q      <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      p_clock_q     <= ~p_clock_q;
      frame_start_q <= frame_start_d;
      if (tick) begin
        state_q    <= state_d;
        h_q        <= h_d;
        v_q        <= v_d;
        vsync_q    <= vsync_d;
        href_q     <= href_d;
        p_data_q   <= p_data_d;
        underrun_q <= underrun_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tick && fetch) lo_q <= pix_word[7:0];
  end

  assign p_clock     = p_clock_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign p_data      = p_data_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Bench for dvp_tx: frame-position reference model compared every clk, plus directed timing checks.
module tb_dvp_tx;

  localparam int HA = 4, VA = 3, HB = 6, VS = 1, VBP = 1, VFP = 1;
  localparam int LL = 2 * HA + HB;
  localparam int FL = (VS + VBP + VA + VFP) * LL;
  localparam logic [15:0] FILL = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, p_clock, vsync, href, frame_start, underrun;
  logic [7:0]  p_data;

  dvp_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BP_LINES(VBP), .V_FP_LINES(VFP),
    .UNDERRUN_FILL(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .p_clock(p_clock), .vsync(vsync), .href(href), .p_data(p_data),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position p (in pclk periods) inside the frame timeline.
  bit        m_pclk = 0, m_in = 0;
  int        m_p = 0, m_n = 0;
  logic [7:0] m_lo = '0;
  bit        e_vs = 0, e_hr = 0, e_fs = 0, e_un = 0, e_rdy = 0;
  logic [7:0] e_pd = '0;

  function automatic bit is_href(input int p);
    int line, h;
    line = p / LL;
    h    = p % LL;
    return (line >= VS + VBP) && (line < VS + VBP + VA) && (h < 2 * HA);
  endfunction

  function automatic bit is_fetch(input int p);
    return is_href(p) && ((p % LL) % 2 == 0);
  endfunction

  task automatic model_step();
    bit tk, start;
    logic [15:0] word;
    if (!rst_n) begin
      m_pclk = 0; m_in = 0; m_p = 0;
      e_vs = 0; e_hr = 0; e_pd = '0; e_fs = 0; e_un = 0; e_rdy = 0;
      return;
    end
    tk = m_pclk;
    m_pclk = !m_pclk;
    e_fs = 0;
    if (tk) begin
      start = 0;
      if (!m_in) begin
        if (enable) begin m_in = 1; m_p = 0; start = 1; end
      end else begin
        m_p++;
        if (m_p == FL) begin
          m_p = 0;
          if (enable) start = 1;
          else        m_in = 0;
        end
      end
      e_vs = m_in && (m_p / LL < VS);
      e_hr = m_in && is_href(m_p);
      if (start) begin e_fs = 1; e_un = 0; end
      if (e_hr && is_fetch(m_p)) begin
        word = pix_valid ? 16'h0100 + 16'(m_n) : FILL;
        if (pix_valid) m_n++;
        else           e_un = 1;
        e_pd = word[15:8];
        m_lo = word[7:0];
      end else if (e_hr) begin
        e_pd = m_lo;
      end else begin
        e_pd = '0;
      end
    end
    e_rdy = m_pclk && m_in && (m_p + 1 < FL) && is_fetch(m_p + 1);
  endtask

  // Stimulus state and measurements
  int vmode = 0, vprob = 75, src_n = 0, skip_idx = 0;
  bit skip_done = 0, under_seen = 0;
  int cyc = 0, fs_count = 0, fs_cyc = 0, fs_gap = 0;
  int ready_cnt = 0, href_cnt = 0, fr_ready = 0, fr_href = 0;
  int vs_rise = 0, vs_fall = 0, vs_width = 0, hr_gap = 0;
  bit hr_armed = 0, prev_vs = 0, prev_hr = 0, cap_en = 0;
  int cap_cnt = 0;
  logic [7:0] cap [8];
  logic s_vs, s_hr;
  logic [7:0] s_pd;

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check_eq("p_clock", p_clock, m_pclk);
      check_eq("vsync", vsync, e_vs);
      check_eq("href", href, e_hr);
      check_eq("p_data", p_data, e_pd);
      check_eq("pix_ready", pix_ready, e_rdy);
      check_eq("frame_start", frame_start, e_fs);
      check_eq("underrun", underrun, e_un);

      if (frame_start === 1'b1) begin
        fs_count++;
        fs_gap = cyc - fs_cyc;
        fs_cyc = cyc;
        fr_ready = ready_cnt;
        fr_href = href_cnt;
        ready_cnt = 0;
        href_cnt = 0;
      end
      ready_cnt += int'(pix_ready);
      href_cnt  += int'(href);
      if (vsync && !prev_vs) vs_rise = cyc;
      if (!vsync && prev_vs) begin vs_width = cyc - vs_rise; vs_fall = cyc; hr_armed = 1; end
      if (href && !prev_hr && hr_armed) begin hr_gap = cyc - vs_fall; hr_armed = 0; end
      if (cap_en && !p_clock && href && cap_cnt < 8) begin cap[cap_cnt] = p_data; cap_cnt++; end
      if (underrun) under_seen = 1;
      prev_vs = vsync;
      prev_hr = href;
      s_vs = vsync; s_hr = href; s_pd = p_data;

      pix_data = 16'h0100 + 16'(src_n);
      case (vmode)
        0:       pix_valid = 1'b1;
        1:       pix_valid = !(src_n == skip_idx && !skip_done);
        default: pix_valid = ($urandom_range(99) < vprob);
      endcase
      if (!pix_valid && pix_ready) skip_done = 1;
      if (pix_valid && pix_ready) src_n++;

      @(posedge clk);
      model_step();
      #1;
      if (p_clock === 1'b1) begin
        check_eq("rise_vsync", vsync, s_vs);
        check_eq("rise_href", href, s_hr);
        check_eq("rise_pdata", p_data, s_pd);
      end
    end
  endtask

  task automatic wait_fs(input int bound);
    int fs0, k;
    fs0 = fs_count;
    k = 0;
    while (fs_count == fs0 && k < bound) begin run_cycles(1); k++; end
    check_eq("wait_frame_start", fs_count != fs0, 1);
  endtask

  initial begin
    int k, fs0, lat;
    logic [7:0] exp_bytes [8];
    exp_bytes = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03};

    // Reset, then first frame with an always-valid stream
    run_cycles(3);
    rst_n = 1'b1;
    enable = 1'b1;
    vmode = 0;
    cap_en = 1;
    run_cycles(150);
    check_eq("first_fs_once", fs_count, 1);
    check_eq("vsync_width", vs_width, 28);
    check_eq("href_after_vsync", hr_gap, 28);
    for (int i = 0; i < 8; i++) check_eq($sformatf("line0_byte%0d", i), cap[i], exp_bytes[i]);
    cap_en = 0;

    // Continuous frames
    run_cycles(400);
    check_eq("fs_spacing", fs_gap, 168);
    check_eq("ready_per_frame", fr_ready, 12);
    check_eq("href_clks_per_frame", fr_href, 48);

    // Slot 5 of a frame finds pix_valid low
    wait_fs(400);
    vmode = 1;
    skip_idx = src_n + 5;
    skip_done = 0;
    under_seen = 0;
    wait_fs(400);
    check_eq("fill_slot_taken", skip_done, 1);
    check_eq("underrun_seen", under_seen, 1);
    check_eq("underrun_cleared", underrun, 0);

    // Random valid, then drop enable in the second active line
    vmode = 2;
    run_cycles(340);
    k = 0;
    while (!(m_in && m_p / LL == VS + VBP + 1) && k < 400) begin run_cycles(1); k++; end
    check_eq("reach_line2", k < 400, 1);
    enable = 1'b0;
    k = 0;
    while (m_in && k < 400) begin run_cycles(1); k++; end
    fs0 = fs_count;
    run_cycles(60);
    check_eq("idle_no_fs", fs_count - fs0, 0);
    check_eq("idle_vsync", vsync, 0);
    enable = 1'b1;
    lat = 0;
    while (fs_count == fs0 && lat < 6) begin run_cycles(1); lat++; end
    check_eq("reenable_fs_in_2clk", (fs_count != fs0) && (lat <= 3), 1);

    // Reset for one clk in the middle of href
    run_cycles(200);
    k = 0;
    while (!e_hr && k < 300) begin run_cycles(1); k++; end
    rst_n = 1'b0;
    run_cycles(1);
    rst_n = 1'b1;
    check_eq("rst_p_clock", p_clock, 0);
    check_eq("rst_vsync", vsync, 0);
    check_eq("rst_href", href, 0);
    check_eq("rst_p_data", p_data, 0);
    check_eq("rst_pix_ready", pix_ready, 0);
    check_eq("rst_underrun", underrun, 0);
    run_cycles(400);
    check_eq("post_rst_spacing", fs_gap, 168);
    check_eq("post_rst_ready", fr_ready, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
